// File: rtl/vga_mono_scanout.sv
// 1 bpp scanout: 1024x768@60 timing, word FIFO, LSB-first pixel shifter.
// Optional `SCANOUT_TEST_PATTERN_EN adds a test_pattern checkerboard input.
module vga_mono_scanout #(
  parameter int C_resolution_x      = 1024,
  parameter int C_hsync_front_porch = 24,
  parameter int C_hsync_pulse       = 136,
  parameter int C_hsync_back_porch  = 160,
  parameter int C_resolution_y      = 768,
  parameter int C_vsync_front_porch = 3,
  parameter int C_vsync_pulse       = 6,
  parameter int C_vsync_back_porch  = 29,
  parameter int C_bits_x            = 11,
  parameter int C_bits_y            = 11,
  parameter int C_fifo_depth        = 8
) (
  input  logic        clk_pixel,
  input  logic        rstn,
`ifdef SCANOUT_TEST_PATTERN_EN
  input  logic        test_pattern,
`endif
  input  logic [31:0] word_data,
  input  logic        word_valid,
  output logic        word_ready,
  output logic        frame_start,
  output logic        underflow,
  output logic [1:0]  vga_r,
  output logic [1:0]  vga_g,
  output logic [1:0]  vga_b,
  output logic        vga_hsync,
  output logic        vga_vsync,
  output logic        vga_blank
);

  localparam int XW = C_bits_x;
  localparam int YW = C_bits_y;
  localparam int HT = C_resolution_x + C_hsync_front_porch
                    + C_hsync_pulse + C_hsync_back_porch;
  localparam int VT = C_resolution_y + C_vsync_front_porch
                    + C_vsync_pulse + C_vsync_back_porch;
  localparam int HS = C_resolution_x + C_hsync_front_porch;
  localparam int VS = C_resolution_y + C_vsync_front_porch;
  localparam int AW = (C_fifo_depth > 1) ? $clog2(C_fifo_depth) : 1;

  localparam logic [XW-1:0] H_ACT  = XW'(C_resolution_x);
  localparam logic [XW-1:0] H_SS   = XW'(HS);
  localparam logic [XW-1:0] H_SE   = XW'(HS + C_hsync_pulse);
  localparam logic [XW-1:0] H_LAST = XW'(HT - 1);
  localparam logic [YW-1:0] V_ACT  = YW'(C_resolution_y);
  localparam logic [YW-1:0] V_SS   = YW'(VS);
  localparam logic [YW-1:0] V_SE   = YW'(VS + C_vsync_pulse);
  localparam logic [YW-1:0] V_LAST = YW'(VT - 1);
  localparam logic [AW:0]   FULL   = (AW+1)'(C_fifo_depth);

  logic [XW-1:0] x_q, x_d;
  logic [YW-1:0] y_q, y_d;
  logic [AW-1:0] wr_q, wr_d, rd_q, rd_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [31:0]   sh_q, sh_d;
  logic [31:0]   mem_q [C_fifo_depth];
  logic          rdy_q, rdy_d;
  logic          uf_q, uf_d;
  logic          pix_q, pix_d;
  logic          hs_q, vs_q, bl_q;
  logic          active, load, flush, flush_nx;
  logic          empty, push, pop, tp;

`ifdef SCANOUT_TEST_PATTERN_EN
  assign tp = test_pattern;
`else
  assign tp = 1'b0;
`endif

  always_comb begin
    x_d = x_q + XW'(1);
    y_d = y_q;
    if (x_q == H_LAST) begin
      x_d = '0;
      y_d = (y_q == V_LAST) ? '0 : y_q + YW'(1);
    end
  end

  assign active   = (x_q < H_ACT) && (y_q < V_ACT);
  assign load     = active && (x_q[4:0] == 5'd0);
  assign flush    = (x_q == '0) && (y_q == V_ACT);
  assign flush_nx = (x_d == '0) && (y_d == V_ACT);
  assign empty    = (cnt_q == '0);
  assign push     = word_valid && rdy_q;
  assign pop      = load && !empty && !tp;

  always_comb begin
    wr_d  = wr_q;
    rd_d  = rd_q;
    cnt_d = cnt_q;
    if (flush) begin
      wr_d  = '0;
      rd_d  = '0;
      cnt_d = '0;
    end else begin
      if (push) wr_d = wr_q + AW'(1);
      if (pop)  rd_d = rd_q + AW'(1);
      unique case ({push, pop})
        2'b10:   cnt_d = cnt_q + (AW+1)'(1);
        2'b01:   cnt_d = cnt_q - (AW+1)'(1);
        default: cnt_d = cnt_q;
      endcase
    end
    // ready is registered, so it looks one cycle ahead at fill level and flush
    rdy_d = (cnt_d != FULL) && !flush_nx;
  end

  always_comb begin
    sh_d  = sh_q;
    pix_d = 1'b0;
    uf_d  = uf_q;
    if (active) begin
      unique case (1'b1)
        tp: pix_d = x_q[5] ^ y_q[5];
        load: begin
          sh_d  = empty ? '0 : mem_q[rd_q];
          uf_d  = uf_q | empty;
          pix_d = sh_d[0];
        end
        default: begin
          sh_d  = sh_q >> 1;
          pix_d = sh_d[0];
        end
      endcase
    end
  end

  always_ff @(posedge clk_pixel) begin
    if (push) mem_q[wr_q] <= word_data;
  end

  always_ff @(posedge clk_pixel or negedge rstn) begin
    if (!rstn) begin
      x_q   <= '0;
      y_q   <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
      sh_q  <= '0;
      rdy_q <= 1'b0;
      uf_q  <= 1'b0;
      pix_q <= 1'b0;
      hs_q  <= 1'b1;
      vs_q  <= 1'b1;
      bl_q  <= 1'b1;
    end else begin
      x_q   <= x_d;
      y_q   <= y_d;
      wr_q  <= wr_d;
      rd_q  <= rd_d;
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
      rdy_q <= rdy_d;
      uf_q  <= uf_d;
      pix_q <= pix_d;
      hs_q  <= !((x_q >= H_SS) && (x_q < H_SE));
      vs_q  <= !((y_q >= V_SS) && (y_q < V_SE));
      bl_q  <= !active;
    end
  end

  assign word_ready  = rdy_q;
  assign frame_start = flush;
  assign underflow   = uf_q;
  assign vga_r       = {2{pix_q}};
  assign vga_g       = {2{pix_q}};
  assign vga_b       = {2{pix_q}};
  assign vga_hsync   = hs_q;
  assign vga_vsync   = vs_q;
  assign vga_blank   = bl_q;

endmodule
